pov_spi_loader: RTL and testbench
=================================

Name: pov_spi_loader

Overview:
- Upstream stage of the POV vector consumers: the wall tracer, map overlay and debug overlay.
- Receives a new point-of-view (player, facing and view-plane vectors) from an external SPI master.
- Holds each received frame in a shadow register and commits it to the live outputs only on the rising edge of vsync, so vectors never change mid-frame.
- Outputs reset defaults until the first valid frame is committed.

Parameters:
- QM, 10, integer bits of each fixed-point vector component (signed, two's complement).
- QN, 10, fractional bits of each component.
- FW = QM+QN (derived, 20), width of one component.
- FRAME_BITS = 6*FW (derived, 120), payload bits per SPI frame.

Ports:
- clk  in  1  system (pixel) clock
- reset  in  1  synchronous, active-high
- vsync  in  1  active-high vsync from vga_sync; commit trigger
- i_sclk  in  1  SPI clock, asynchronous, mode 0
- i_mosi  in  1  SPI data, asynchronous
- i_ss_n  in  1  SPI select, active-low, asynchronous
- playerX, playerY  out  FW each  live player position
- facingX, facingY  out  FW each  live facing vector
- vplaneX, vplaneY  out  FW each  live view-plane vector
- o_pending  out  1  a complete frame is waiting for the next vsync commit

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values (QN=10):
  - playerX = playerY = 0x00600 (1.5)
  - facingX = 0x00400 (1.0), facingY = 0
  - vplaneX = 0, vplaneY = 0xFFE00 (-0.5)
  - shadow register = 0, bit counter = 0, o_pending = 0
- Input synchronisers:
  - i_sclk, i_mosi and i_ss_n each pass through two flops.
  - A third flop on sclk detects its rising edge.
  - Edge-to-sample latency is 3 clk cycles.
  - SCLK must not exceed clk/4 and each level must last at least 2 clk.
- FSM:
  - IDLE: synced ss_n high. Bit counter is held at 0. Go to SHIFT when synced ss_n goes low.
  - SHIFT: on each sclk rising edge, shift synced mosi into the receive shift register (MSB first) and increment the counter.
    - When the counter reaches FRAME_BITS, go to DONE.
    - If ss_n rises before then, discard the partial frame and go to IDLE. The shadow register and o_pending are untouched.
  - DONE: lasts one cycle.
    - Copy the receive register to the shadow register and set o_pending=1.
    - Go to DRAIN.
  - DRAIN: ignore all further sclk edges. Go to IDLE when ss_n goes high.
- Frame field order (MSB first): playerX, playerY, facingX, facingY, vplaneX, vplaneY.
- Commit:
  - A vsync rising edge is detected from vsync and a 1-cycle delayed copy.
  - On that edge, if o_pending=1, all six outputs load from the shadow register in the same clk edge, and o_pending clears.
  - If o_pending=0, the outputs hold.
- Boundary conditions:
  - DONE and vsync rising edge in the same cycle: the commit uses the pre-update o_pending. A pending-free frame is therefore deferred to the next vsync.
  - New frame completes while o_pending=1: the shadow register is overwritten (latest wins) and o_pending stays 1.
  - Reset mid-frame: everything returns to reset values. The SPI master's in-progress frame is lost.
  - ss_n held low permanently after DONE: the block stays in DRAIN and accepts no new frame until ss_n deasserts.
  - The outputs change only at reset or on a vsync commit.

Optional Feature:
- Macro: POV_SPI_CHECKSUM_EN
- Defined:
  - The frame is FRAME_BITS+8 bits. The last 8 bits are the XOR of all payload bytes; the payload is left-padded with zeros to a byte multiple (120 bits is exactly 15 bytes).
  - On mismatch, DONE does not update the shadow register or o_pending, and sticky output o_csum_err (1 bit, reset 0) is set.
  - o_csum_err is cleared only by reset.
- Undefined:
  - The frame is FRAME_BITS bits with no checksum.
  - o_csum_err does not exist.

Test Plan:
- Reset and idle: assert reset for 2 cycles with no SPI activity -> playerX=0x00600, facingX=0x00400, vplaneY=0xFFE00, o_pending=0.
- Full frame then vsync: shift 120 bits with playerX=0x00A00, playerY=0x00C00, facing=(0,0x00400), vplane=(0x00200,0), then raise ss_n -> o_pending=1 and outputs unchanged. On the next vsync rise -> all six outputs take the new values one cycle after the edge is sampled, and o_pending=0.
- Aborted frame: raise ss_n after 57 bits -> shadow register, o_pending and outputs unchanged. A following full valid frame is accepted normally.
- Latest wins: send frame A (playerX=0x00800), then frame B (playerX=0x00900) before vsync -> after vsync, playerX=0x00900.
- Collision: align DONE with the vsync-rise detection cycle -> outputs unchanged at this vsync; new values appear at the following vsync.
- Overrun and reset: clock 130 bits with ss_n low -> only the first 120 bits are used. Asserting reset mid-frame -> defaults are restored and o_pending=0. With POV_SPI_CHECKSUM_EN defined, a bad checksum byte -> o_csum_err=1 and outputs stay unchanged.

Source files
------------

// File: rtl/pov_spi_loader.sv
// pov_spi_loader: receives a point-of-view frame (player, facing, view-plane
// vectors) from an external SPI master (mode 0), holds it in a shadow register
// and commits it to the live outputs on the next vsync rising edge.
// Optional build macro POV_SPI_CHECKSUM_EN appends an 8-bit XOR checksum to
// each frame and adds the sticky o_csum_err output.
module pov_spi_loader #(
  parameter int unsigned QM = 10,
  parameter int unsigned QN = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               i_sclk,
  input  logic               i_mosi,
  input  logic               i_ss_n,
  output logic [QM+QN-1:0]   playerX,
  output logic [QM+QN-1:0]   playerY,
  output logic [QM+QN-1:0]   facingX,
  output logic [QM+QN-1:0]   facingY,
  output logic [QM+QN-1:0]   vplaneX,
  output logic [QM+QN-1:0]   vplaneY,
`ifdef POV_SPI_CHECKSUM_EN
  output logic               o_csum_err,
`endif
  output logic               o_pending
);

  localparam int unsigned FW         = QM + QN;
  localparam int unsigned FRAME_BITS = 6 * FW;
`ifdef POV_SPI_CHECKSUM_EN
  localparam int unsigned CSUM_BITS  = 8;
  localparam int unsigned PAD_BYTES  = (FRAME_BITS + 7) / 8;
`else
  localparam int unsigned CSUM_BITS  = 0;
`endif
  localparam int unsigned FRAME_TOTAL = FRAME_BITS + CSUM_BITS;
  localparam int unsigned CW          = $clog2(FRAME_TOTAL + 1);

  // Reset vectors: player at (1.5,1.5), facing (1,0), view plane (0,-0.5)
  localparam logic [FW-1:0] RST_PX   = FW'(3) << (QN - 1);
  localparam logic [FW-1:0] RST_FX   = FW'(1) << QN;
  localparam logic [FW-1:0] RST_VY   = ~(FW'(1) << (QN - 1)) + FW'(1);
  localparam logic [FRAME_BITS-1:0] LIVE_RST =
    {RST_PX, RST_PX, RST_FX, FW'(0), FW'(0), RST_VY};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [FRAME_TOTAL-1:0]  rx_q, rx_d;
  logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
  logic [FRAME_BITS-1:0]   live_q, live_d;
  logic                    pending_q, pending_d;
  logic                    sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic                    mosi_s1_q, mosi_s2_q;
  logic                    ss_s1_q, ss_s2_q;
  logic                    vsync_q;
  logic                    sclk_rise;
  logic                    vs_rise;
  logic                    frame_ok;
  logic [FRAME_BITS-1:0]   rx_payload;
`ifdef POV_SPI_CHECKSUM_EN
  logic                    csum_err_q, csum_err_d;
  logic [7:0]              csum_calc;
  logic [PAD_BYTES*8-1:0]  padded;
`endif

  assign sclk_rise  = sclk_s2_q & ~sclk_s3_q;
  assign vs_rise    = vsync & ~vsync_q;
  assign rx_payload = rx_q[FRAME_TOTAL-1 -: FRAME_BITS];

`ifdef POV_SPI_CHECKSUM_EN
  // XOR of all payload bytes, payload left-padded with zeros to a byte multiple
  always_comb begin
    padded                   = '0;
    padded[FRAME_BITS-1:0]   = rx_payload;
    csum_calc                = 8'h00;
    for (int unsigned b = 0; b < PAD_BYTES; b++) begin
      csum_calc = csum_calc ^ padded[b*8 +: 8];
    end
  end
`endif

  // Synchronisers, FSM state and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      vsync_q    <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      shadow_q   <= '0;
      live_q     <= LIVE_RST;
      pending_q  <= 1'b0;
`ifdef POV_SPI_CHECKSUM_EN
      csum_err_q <= 1'b0;
`endif
    end else begin
      sclk_s1_q  <= i_sclk;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      mosi_s1_q  <= i_mosi;
      mosi_s2_q  <= mosi_s1_q;
      ss_s1_q    <= i_ss_n;
      ss_s2_q    <= ss_s1_q;
      vsync_q    <= vsync;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      shadow_q   <= shadow_d;
      live_q     <= live_d;
      pending_q  <= pending_d;
`ifdef POV_SPI_CHECKSUM_EN
      csum_err_q <= csum_err_d;
`endif
    end
  end

  // Next-state: SPI receive FSM, shadow capture and vsync commit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    shadow_d  = shadow_q;
    live_d    = live_q;
    pending_d = pending_q;
    frame_ok  = 1'b0;
`ifdef POV_SPI_CHECKSUM_EN
    csum_err_d = csum_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!ss_s2_q) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_s2_q) begin
          // Partial frame is discarded; shadow and pending stay as they are
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sclk_rise) begin
          rx_d  = {rx_q[FRAME_TOTAL-2:0], mosi_s2_q};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(FRAME_TOTAL - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DRAIN;
`ifdef POV_SPI_CHECKSUM_EN
        if (csum_calc == rx_q[7:0]) begin
          frame_ok = 1'b1;
        end else begin
          csum_err_d = 1'b1;
        end
`else
        frame_ok = 1'b1;
`endif
      end
      ST_DRAIN: begin
        // Extra sclk edges are ignored until the master releases select
        if (ss_s2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Commit uses the pre-update pending flag and shadow contents
    if (vs_rise && pending_q) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end

    // A newly accepted frame always overwrites the shadow (latest wins)
    if (frame_ok) begin
      shadow_d  = rx_payload;
      pending_d = 1'b1;
    end
  end

  assign playerX    = live_q[6*FW-1 -: FW];
  assign playerY    = live_q[5*FW-1 -: FW];
  assign facingX    = live_q[4*FW-1 -: FW];
  assign facingY    = live_q[3*FW-1 -: FW];
  assign vplaneX    = live_q[2*FW-1 -: FW];
  assign vplaneY    = live_q[FW-1   -: FW];
  assign o_pending  = pending_q;
`ifdef POV_SPI_CHECKSUM_EN
  assign o_csum_err = csum_err_q;
`endif

endmodule

// File: tb/tb_pov_spi_loader.sv
// Testbench for pov_spi_loader: table of SPI frames with expected pending flag
// and expected live outputs after the following vsync, plus directed
// sequences for latest-wins, DONE/vsync collision, reset mid-frame and
// (with POV_SPI_CHECKSUM_EN) a bad checksum.
module tb_pov_spi_loader;

`ifdef POV_SPI_CHECKSUM_EN
  localparam int FTOT = 128;
`else
  localparam int FTOT = 120;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic [19:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic        pending;
`ifdef POV_SPI_CHECKSUM_EN
  logic        csum_err;
`endif

  int checks = 0;
  int failures = 0;

  pov_spi_loader dut (
    .clk     (clk),
    .reset   (reset),
    .vsync   (vsync),
    .i_sclk  (sclk),
    .i_mosi  (mosi),
    .i_ss_n  (ss_n),
    .playerX (playerX),
    .playerY (playerY),
    .facingX (facingX),
    .facingY (facingY),
    .vplaneX (vplaneX),
    .vplaneY (vplaneY),
`ifdef POV_SPI_CHECKSUM_EN
    .o_csum_err (csum_err),
`endif
    .o_pending (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [119:0] pay;
    int           nbits;
    logic         exp_pend;
    logic [119:0] exp_out;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_live(input string tag, input logic [119:0] e);
    chk({tag, ".playerX"}, 32'(playerX), 32'(e[119:100]));
    chk({tag, ".playerY"}, 32'(playerY), 32'(e[99:80]));
    chk({tag, ".facingX"}, 32'(facingX), 32'(e[79:60]));
    chk({tag, ".facingY"}, 32'(facingY), 32'(e[59:40]));
    chk({tag, ".vplaneX"}, 32'(vplaneX), 32'(e[39:20]));
    chk({tag, ".vplaneY"}, 32'(vplaneY), 32'(e[19:0]));
  endtask

  // Frame bits top-aligned in a 160-bit vector; trailing bits are ones
  function automatic logic [159:0] make_bits(input logic [119:0] pay, input logic bad);
    logic [159:0] b;
    logic [7:0]   cs;
    b = '1;
    b[159 -: 120] = pay;
    cs = 8'h00;
    for (int i = 0; i < 15; i++) cs = cs ^ pay[i*8 +: 8];
    if (bad) cs = cs ^ 8'h01;
`ifdef POV_SPI_CHECKSUM_EN
    b[39:32] = cs;
`endif
    return b;
  endfunction

  // Mode-0 SPI transfer; sclk levels last 3 clk each. coll aligns the vsync
  // rise with the DONE cycle of the last bit.
  task automatic spi_send(input logic [159:0] bits, input int nbits,
                          input bit release_ss, input bit coll);
    @(posedge clk); #1;
    ss_n = 1'b0;
    sclk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[159 - i];
      repeat (3) @(posedge clk);
      #1 sclk = 1'b1;
      if (coll && i == nbits - 1) begin
        repeat (3) @(posedge clk);
        #1 vsync = 1'b1;
      end else begin
        repeat (3) @(posedge clk);
      end
      #1 sclk = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    if (release_ss) ss_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk); #1 vsync = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    ss_n  = 1'b1;
    sclk  = 1'b0;
    vsync = 1'b0;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    logic [119:0] rst_exp;
    logic [119:0] prev;
    logic [119:0] pa, pb, pc, pd;

    rst_exp = {20'h00600, 20'h00600, 20'h00400, 20'h00000, 20'h00000, 20'hFFE00};

    tbl[0] = '{pay: {20'h00A00, 20'h00C00, 20'h00000, 20'h00400, 20'h00200, 20'h00000},
               nbits: FTOT, exp_pend: 1'b1,
               exp_out: {20'h00A00, 20'h00C00, 20'h00000, 20'h00400, 20'h00200, 20'h00000}};
    tbl[1] = '{pay: {20'h12345, 20'h6789A, 20'hBCDEF, 20'h13579, 20'h2468A, 20'h0F0F0},
               nbits: 57, exp_pend: 1'b0,
               exp_out: {20'h00A00, 20'h00C00, 20'h00000, 20'h00400, 20'h00200, 20'h00000}};
    tbl[2] = '{pay: {20'hFF800, 20'h00100, 20'hFFC00, 20'h00000, 20'h00000, 20'h00266},
               nbits: FTOT, exp_pend: 1'b1,
               exp_out: {20'hFF800, 20'h00100, 20'hFFC00, 20'h00000, 20'h00000, 20'h00266}};
    tbl[3] = '{pay: {20'h00300, 20'h00500, 20'h00400, 20'h00400, 20'hFFF00, 20'h00100},
               nbits: FTOT + 10, exp_pend: 1'b1,
               exp_out: {20'h00300, 20'h00500, 20'h00400, 20'h00400, 20'hFFF00, 20'h00100}};

    // Reset and idle
    do_reset();
    chk_live("reset", rst_exp);
    chk("reset.pending", 32'(pending), 32'd0);
`ifdef POV_SPI_CHECKSUM_EN
    chk("reset.csum_err", 32'(csum_err), 32'd0);
`endif

    // Table: frame, check pending and unchanged outputs, vsync, check commit
    prev = rst_exp;
    for (int v = 0; v < 4; v++) begin
      spi_send(make_bits(tbl[v].pay, 1'b0), tbl[v].nbits, 1'b1, 1'b0);
      chk($sformatf("vec%0d.pend_before", v), 32'(pending), 32'(tbl[v].exp_pend));
      chk_live($sformatf("vec%0d.hold", v), prev);
      vsync_pulse();
      chk_live($sformatf("vec%0d.commit", v), tbl[v].exp_out);
      chk($sformatf("vec%0d.pend_after", v), 32'(pending), 32'd0);
      prev = tbl[v].exp_out;
    end

    // Latest wins: two frames before one vsync
    pa = {20'h00800, 20'h00100, 20'h00200, 20'h00300, 20'h00400, 20'h00500};
    pb = {20'h00900, 20'h00A00, 20'h00B00, 20'h00C00, 20'h00D00, 20'h00E00};
    spi_send(make_bits(pa, 1'b0), FTOT, 1'b1, 1'b0);
    spi_send(make_bits(pb, 1'b0), FTOT, 1'b1, 1'b0);
    chk("latest.pend", 32'(pending), 32'd1);
    chk_live("latest.hold", prev);
    vsync_pulse();
    chk_live("latest.commit", pb);
    chk("latest.pend_after", 32'(pending), 32'd0);
    prev = pb;

    // Collision: DONE in the same cycle as the vsync rise detection
    pc = {20'h00111, 20'h00222, 20'h00333, 20'hFF444, 20'h00555, 20'hFF666};
    spi_send(make_bits(pc, 1'b0), FTOT, 1'b1, 1'b1);
    chk("coll.pend", 32'(pending), 32'd1);
    chk_live("coll.hold", prev);
    @(posedge clk); #1 vsync = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_live("coll.still_hold", prev);
    vsync_pulse();
    chk_live("coll.commit", pc);
    chk("coll.pend_after", 32'(pending), 32'd0);
    prev = pc;

`ifdef POV_SPI_CHECKSUM_EN
    // Bad checksum: frame rejected, sticky error set
    spi_send(make_bits(pa, 1'b1), FTOT, 1'b1, 1'b0);
    chk("csum.err", 32'(csum_err), 32'd1);
    chk("csum.pend", 32'(pending), 32'd0);
    vsync_pulse();
    chk_live("csum.hold", prev);
`endif

    // Reset mid-frame with a frame already pending
    pd = {20'h00777, 20'h00777, 20'h00777, 20'h00777, 20'h00777, 20'h00777};
    spi_send(make_bits(pd, 1'b0), FTOT, 1'b1, 1'b0);
    chk("rstmid.pend_before", 32'(pending), 32'd1);
    spi_send(make_bits(pa, 1'b0), 30, 1'b0, 1'b0);
    do_reset();
    chk_live("rstmid.defaults", rst_exp);
    chk("rstmid.pend", 32'(pending), 32'd0);
`ifdef POV_SPI_CHECKSUM_EN
    chk("rstmid.csum_err", 32'(csum_err), 32'd0);
`endif
    vsync_pulse();
    chk_live("rstmid.after_vsync", rst_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
